// File: rtl/spike_rate_decoder_if.sv
// Result channel of the spike rate decoder: recovered rate plus valid/ready handshake.
// The master drives the rate and valid; the slave (readout logic) drives ready.
interface spike_rate_decoder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] rate;
  logic             valid;
  logic             ready;

  modport master (output rate, output valid, input ready);
  modport slave  (input rate, input valid, output ready);
endinterface

// File: rtl/spike_rate_decoder.sv
// Rate-coded spike receiver: counts spikes over a 2**WIDTH-1 cycle window and
// presents the count (the originating weight) on a valid/ready result channel.
module spike_rate_decoder #(
  parameter int WIDTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic                        cont_i,
  input  logic                        spike_i,
  output logic                        busy_o,
  output logic                        overrun_o,
  spike_rate_decoder_if.master        rate_if
);

  typedef enum logic {IDLE, COUNT} state_e;

  // The completion edge is the one where cyc_q has already seen 2**WIDTH-2 samples.
  localparam logic [WIDTH-1:0] LastCyc = WIDTH'((1 << WIDTH) - 2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cyc_q, cyc_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] rate_q, rate_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic windowDone;
  logic startAccept;

  assign windowDone  = (state_q == COUNT) && (cyc_q == LastCyc);
  assign startAccept = (state_q == IDLE) && start_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = COUNT;
      COUNT:   if (windowDone && !cont_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o        = (state_q == COUNT);
    overrun_o     = overrun_q;
    rate_if.rate  = rate_q;
    rate_if.valid = valid_q;
  end

  // Counters restart on an accepted start and at every completion, so continuous
  // windows follow each other with no gap.
  always_comb begin
    cyc_d     = cyc_q;
    acc_d     = acc_q;
    rate_d    = rate_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (startAccept) begin
      cyc_d     = '0;
      acc_d     = '0;
      overrun_d = 1'b0;
    end else if (state_q == COUNT) begin
      if (windowDone) begin
        cyc_d = '0;
        acc_d = '0;
      end else begin
        cyc_d = cyc_q + WIDTH'(1);
        acc_d = acc_q + WIDTH'(spike_i);
      end
    end

    // A completion always wins over a consume; it only counts as an overrun when
    // the previous result is neither consumed on this edge nor earlier.
    if (windowDone) begin
      rate_d  = acc_q + WIDTH'(spike_i);
      valid_d = 1'b1;
      if (valid_q && !rate_if.ready) overrun_d = 1'b1;
    end else if (valid_q && rate_if.ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q     <= '0;
      acc_q     <= '0;
      rate_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cyc_q     <= cyc_d;
      acc_q     <= acc_d;
      rate_q    <= rate_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: an 8-bit instance driven by a wrapping
// neuron model and raw patterns, plus a 4-bit instance for the short window.
module tb_spike_rate_decoder;

  logic clk;
  logic rstN;
  logic start8, cont8, spike8;
  logic busy8, overrun8;
  logic start4, cont4, spike4;
  logic busy4, overrun4;

  int checkCount = 0;
  int errorCount = 0;

  spike_rate_decoder_if #(.WIDTH(8)) if8 ();
  spike_rate_decoder_if #(.WIDTH(4)) if4 ();

  spike_rate_decoder #(.WIDTH(8)) u8 (
    .clk_i     (clk),
    .rst_ni    (rstN),
    .start_i   (start8),
    .cont_i    (cont8),
    .spike_i   (spike8),
    .busy_o    (busy8),
    .overrun_o (overrun8),
    .rate_if   (if8.master)
  );

  spike_rate_decoder #(.WIDTH(4)) u4 (
    .clk_i     (clk),
    .rst_ni    (rstN),
    .start_i   (start4),
    .cont_i    (cont4),
    .spike_i   (spike4),
    .busy_o    (busy4),
    .overrun_o (overrun4),
    .rate_if   (if4.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
      else begin
        errorCount++;
        $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  task automatic startWindow8(input logic spikeOnStart);
    start8 = 1'b1;
    spike8 = spikeOnStart;
    tick();
    start8 = 1'b0;
  endtask

  // Accumulate-and-wrap neuron of weight w, potential restarted at 0 for each window.
  task automatic applyStimulus(input int w, input logic contLast, input logic readyLast);
    int pot;
    pot = 0;
    for (int k = 1; k <= 255; k++) begin
      pot = pot + w;
      if (pot >= 255) begin
        spike8 = 1'b1;
        pot = pot - 255;
      end else begin
        spike8 = 1'b0;
      end
      if (k == 255) begin
        cont8 = contLast;
        if8.ready = readyLast;
      end
      tick();
    end
    cont8 = 1'b0;
    if8.ready = 1'b0;
    spike8 = 1'b0;
  endtask

  task automatic consume8();
    if8.ready = 1'b1;
    tick();
    if8.ready = 1'b0;
  endtask

  task automatic consume4();
    if4.ready = 1'b1;
    tick();
    if4.ready = 1'b0;
  endtask

  initial begin
    rstN = 1'b1;
    start8 = 1'b0; cont8 = 1'b0; spike8 = 1'b0; if8.ready = 1'b0;
    start4 = 1'b0; cont4 = 1'b0; spike4 = 1'b0; if4.ready = 1'b0;
    #1 rstN = 1'b0;
    tick();
    tick();
    checkOutput("reset_rate", if8.rate, 0);
    checkOutput("reset_valid", if8.valid, 0);
    checkOutput("reset_busy", busy8, 0);
    checkOutput("reset_overrun", overrun8, 0);
    rstN = 1'b1;
    tick();

    $display("[TB] neuron weights 191, 0, 255");
    startWindow8(1'b0);
    checkOutput("t1_busy_after_start", busy8, 1);
    applyStimulus(191, 1'b0, 1'b0);
    checkOutput("t1_w191_rate", if8.rate, 191);
    checkOutput("t1_w191_valid", if8.valid, 1);
    checkOutput("t1_w191_busy", busy8, 0);
    consume8();
    checkOutput("t1_consumed_valid", if8.valid, 0);
    startWindow8(1'b0);
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("t1_w0_rate", if8.rate, 0);
    checkOutput("t1_w0_valid", if8.valid, 1);
    consume8();
    startWindow8(1'b0);
    applyStimulus(255, 1'b0, 1'b0);
    checkOutput("t1_w255_rate", if8.rate, 255);
    checkOutput("t1_w255_overrun", overrun8, 0);
    consume8();

    $display("[TB] all-ones with ready held, then spike only on start edge");
    if8.ready = 1'b1;
    startWindow8(1'b1);
    spike8 = 1'b1;
    for (int k = 1; k <= 254; k++) tick();
    checkOutput("t2_valid_before_edge255", if8.valid, 0);
    tick();
    checkOutput("t2_valid_at_edge255", if8.valid, 1);
    checkOutput("t2_rate_all_ones", if8.rate, 255);
    tick();
    checkOutput("t2_valid_one_cycle", if8.valid, 0);
    if8.ready = 1'b0;
    startWindow8(1'b1);
    spike8 = 1'b0;
    for (int k = 1; k <= 255; k++) tick();
    checkOutput("t2_start_spike_ignored", if8.rate, 0);
    checkOutput("t2_start_spike_valid", if8.valid, 1);
    consume8();

    $display("[TB] continuous windows without consumer");
    startWindow8(1'b0);
    applyStimulus(100, 1'b1, 1'b0);
    checkOutput("t3_win1_rate", if8.rate, 100);
    checkOutput("t3_win1_busy", busy8, 1);
    checkOutput("t3_win1_overrun", overrun8, 0);
    applyStimulus(37, 1'b0, 1'b0);
    checkOutput("t3_win2_rate", if8.rate, 37);
    checkOutput("t3_win2_valid", if8.valid, 1);
    checkOutput("t3_win2_overrun", overrun8, 1);
    checkOutput("t3_win2_busy", busy8, 0);
    consume8();
    checkOutput("t3_overrun_sticky", overrun8, 1);
    startWindow8(1'b0);
    checkOutput("t3_start_clears_overrun", overrun8, 0);

    $display("[TB] continuous windows, ready on second completion edge");
    applyStimulus(100, 1'b1, 1'b0);
    checkOutput("t4_win1_rate", if8.rate, 100);
    checkOutput("t4_win1_overrun", overrun8, 0);
    applyStimulus(37, 1'b0, 1'b1);
    checkOutput("t4_win2_rate", if8.rate, 37);
    checkOutput("t4_win2_valid", if8.valid, 1);
    checkOutput("t4_win2_overrun", overrun8, 0);

    $display("[TB] mid-window reset and ignored start");
    if8.ready = 1'b1;
    startWindow8(1'b1);
    if8.ready = 1'b0;
    spike8 = 1'b1;
    for (int k = 1; k <= 100; k++) tick();
    checkOutput("t5_busy_before_reset", busy8, 1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("t5_reset_rate", if8.rate, 0);
    checkOutput("t5_reset_valid", if8.valid, 0);
    checkOutput("t5_reset_busy", busy8, 0);
    checkOutput("t5_reset_overrun", overrun8, 0);
    tick();
    rstN = 1'b1;
    tick();
    tick();
    checkOutput("t5_idle_after_reset", busy8, 0);
    startWindow8(1'b1);
    spike8 = 1'b1;
    for (int k = 1; k <= 254; k++) begin
      start8 = (k == 50);
      tick();
    end
    start8 = 1'b0;
    checkOutput("t5_restart_valid_early", if8.valid, 0);
    checkOutput("t5_restart_busy", busy8, 1);
    tick();
    checkOutput("t5_window_len_valid", if8.valid, 1);
    checkOutput("t5_window_len_rate", if8.rate, 255);
    spike8 = 1'b0;

    $display("[TB] 4-bit window");
    start4 = 1'b1;
    spike4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int k = 1; k <= 14; k++) tick();
    checkOutput("t6_valid_before_edge15", if4.valid, 0);
    tick();
    checkOutput("t6_ones_valid", if4.valid, 1);
    checkOutput("t6_ones_rate", if4.rate, 15);
    checkOutput("t6_ones_busy", busy4, 0);
    consume4();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      spike4 = k[0];
      tick();
    end
    checkOutput("t6_alt_odd_rate", if4.rate, 8);
    consume4();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      spike4 = ~k[0];
      tick();
    end
    checkOutput("t6_alt_even_rate", if4.rate, 7);
    checkOutput("t6_alt_even_overrun", overrun4, 0);
    spike4 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
